// File: rtl/instr_assembler_if.sv
// Instruction-field input channel and instruction-memory write channel of the assembler.
// The master drives session control and fields; the slave (assembler) drives the write port and status.
interface instr_assembler_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        we_im;
    logic [5:0]  im_addr;
    logic [31:0] im_wd;
    logic [6:0]  count;
    logic        done;
    logic        err;

    modport master (
        output start, in_valid, in_last, op_sel, rs, rt, rd, funct, imm, target,
        input  in_ready, we_im, im_addr, im_wd, count, done, err
    );

    modport slave (
        input  start, in_valid, in_last, op_sel, rs, rt, rd, funct, imm, target,
        output in_ready, we_im, im_addr, im_wd, count, done, err
    );
endinterface

// File: rtl/instr_assembler.sv
// Assembles MIPS-style instruction fields into 32-bit words and writes them
// sequentially into a 64-word instruction memory, one word per accepted transfer.
module instr_assembler (
    input  logic               clk,
    input  logic               rst,
    instr_assembler_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        in_ready_s;
    logic        accept_s;
    logic        invalid_s;
    logic        write_s;
    logic        final_s;
    logic [31:0] word_s;
    logic        we_im_r;
    logic [5:0]  im_addr_r;
    logic [31:0] im_wd_r;
    logic [6:0]  count_r;
    logic        done_r;
    logic        err_r;

    function automatic logic [31:0] encode_word(
        input logic [2:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] w;
        case (op)
            3'd0:    w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, f_funct};
            3'd1:    w = {6'b001000, f_rs, f_rt, f_imm};
            3'd2:    w = {6'b000100, f_rs, f_rt, f_imm};
            3'd3:    w = {6'b000010, f_target};
            3'd4:    w = {6'b000011, f_target};
            3'd5:    w = {6'b101011, f_rs, f_rt, f_imm};
            3'd6:    w = {6'b100011, f_rs, f_rt, f_imm};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // in_ready must drop in the very cycle start is seen, so it cannot be a register.
    assign in_ready_s = (state_r == ST_LOAD) && !bus.start && !rst;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign invalid_s  = (bus.op_sel == 3'd7);
    assign write_s    = accept_s && !invalid_s;
    // count_r doubles as the write address; the 64th write ends the session before it can wrap.
    assign final_s    = accept_s && (bus.in_last || (!invalid_s && (count_r == 7'd63)));
    assign word_s     = encode_word(bus.op_sel, bus.rs, bus.rt, bus.rd, bus.funct, bus.imm, bus.target);

    // Session state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Session next-state logic; start restarts from any state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_LOAD;
                else           state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (bus.start)    state_nxt_s = ST_LOAD;
                else if (final_s) state_nxt_s = ST_DONE;
                else              state_nxt_s = ST_LOAD;
            end
            ST_DONE: begin
                if (bus.start) state_nxt_s = ST_LOAD;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Write port register: a registered write issues even if start arrives alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_im_r   <= 1'b0;
            im_addr_r <= 6'd0;
            im_wd_r   <= 32'h0000_0000;
        end else begin
            we_im_r <= write_s;
            if (write_s) begin
                im_addr_r <= count_r[5:0];
                im_wd_r   <= word_s;
            end else begin
                im_addr_r <= im_addr_r;
                im_wd_r   <= im_wd_r;
            end
        end
    end

    // Session status: count, done and sticky err change together with the write they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 7'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (bus.start) begin
            count_r <= 7'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (write_s) count_r <= count_r + 7'd1;
            else         count_r <= count_r;
            if (accept_s && invalid_s) err_r <= 1'b1;
            else                       err_r <= err_r;
            if (final_s) done_r <= 1'b1;
            else         done_r <= done_r;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.we_im    = we_im_r;
    assign bus.im_addr  = im_addr_r;
    assign bus.im_wd    = im_wd_r;
    assign bus.count    = count_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler: a session-level reference model queues expected
// writes at acceptance; a negedge monitor pops and compares whenever a write is due.
module tb_instr_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_assembler_if bus ();
    instr_assembler dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wd;
        logic [6:0]  cnt;
        logic        dn;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   run_mon   = 1'b0;

    // Reference session model
    bit m_loading = 1'b0;
    bit m_done    = 1'b0;
    bit m_err     = 1'b0;
    int m_count   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    endtask

    function automatic logic [31:0] ref_word(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                                             input logic [4:0] d, input logic [5:0] fn, input logic [15:0] im,
                                             input logic [25:0] tg);
        logic [5:0] opc;
        opc = 6'd0;
        if (op == 3'd0) return {6'd0, a, b, d, 5'd0, fn};
        if (op == 3'd3) return {6'd2, tg};
        if (op == 3'd4) return {6'd3, tg};
        if (op == 3'd1) opc = 6'd8;
        if (op == 3'd2) opc = 6'd4;
        if (op == 3'd5) opc = 6'd43;
        if (op == 3'd6) opc = 6'd35;
        return {opc, a, b, im};
    endfunction

    // One clock cycle of stimulus, with model update at the sampling edge.
    task automatic drive(input bit st, input bit v, input bit l, input logic [2:0] op,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                         input bit r);
        bit   rdy;
        exp_t e;
        @(negedge clk);
        rst = r; bus.start = st; bus.in_valid = v; bus.in_last = l; bus.op_sel = op;
        bus.rs = a; bus.rt = b; bus.rd = d; bus.funct = fn; bus.imm = im; bus.target = tg;
        #1;
        rdy = m_loading && !st && !r;
        if (run_mon) begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
            chk("count", {25'd0, bus.count}, 32'(m_count));
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            chk("err", {31'd0, bus.err}, {31'd0, m_err});
        end
        @(posedge clk);
        if (r) begin
            m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0; m_count = 0;
        end else if (st) begin
            m_loading = 1'b1; m_done = 1'b0; m_err = 1'b0; m_count = 0;
        end else if (rdy && v) begin
            if (op == 3'd7) begin
                m_err = 1'b1;
                if (l) begin m_loading = 1'b0; m_done = 1'b1; end
            end else begin
                e.addr = 6'(m_count);
                e.wd   = ref_word(op, a, b, d, fn, im, tg);
                m_count++;
                if (l || m_count == 64) begin m_loading = 1'b0; m_done = 1'b1; end
                e.cnt = 7'(m_count);
                e.dn  = m_done;
                e.er  = m_err;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    endtask

    task automatic go();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    endtask

    // Monitor: any due write must appear exactly now; otherwise we_im must be low.
    always @(negedge clk) begin
        exp_t e;
        if (run_mon) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we_im", {31'd0, bus.we_im}, 32'd1);
                chk("im_addr", {26'd0, bus.im_addr}, {26'd0, e.addr});
                chk("im_wd", bus.im_wd, e.wd);
                chk("wr_count", {25'd0, bus.count}, {25'd0, e.cnt});
                chk("wr_done", {31'd0, bus.done}, {31'd0, e.dn});
                chk("wr_err", {31'd0, bus.err}, {31'd0, e.er});
            end else begin
                chk("we_im_idle", {31'd0, bus.we_im}, 32'd0);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
        run_mon = 1'b1;
        @(negedge clk);
        chk("rst_im_addr", {26'd0, bus.im_addr}, 32'd0);
        chk("rst_im_wd", bus.im_wd, 32'd0);
        idle();

        // Single ADDI with in_last, then valid ignored in DONE
        go();
        drive(1'b0, 1'b1, 1'b1, 3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, 3'd5, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 26'd1, 1'b0);
        idle();

        // R-type then J back-to-back
        go();
        drive(1'b0, 1'b1, 1'b0, 3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 3'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1'b0);
        idle();

        // Invalid op then BEQ
        go();
        drive(1'b0, 1'b1, 1'b0, 3'd7, 5'd3, 5'd4, 5'd5, 6'd6, 16'h1234, 26'd7, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
        idle();

        // 64 LW without in_last, then extra valid cycles must not wrap
        go();
        for (int i = 0; i < 64; i++)
            drive(1'b0, 1'b1, 1'b0, 3'd6, 5'd0, 5'd2, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, 3'd6, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0077, 26'd0, 1'b0);
        idle();

        // Invalid op with in_last ends the session without a write
        go();
        drive(1'b0, 1'b1, 1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        idle();

        // Restart mid-session after 3 writes, start coinciding with in_valid
        go();
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, 3'd1, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(i * 3), 26'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'd5, 5'd7, 5'd7, 5'd7, 6'd7, 16'h7777, 26'd7, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3ABCDEF, 1'b0);
        idle();

        // Start right after an accepted word: the pending write still issues
        go();
        drive(1'b0, 1'b1, 1'b0, 3'd5, 5'd9, 5'd10, 5'd0, 6'd0, 16'hBEEF, 26'd0, 1'b0);
        go();
        drive(1'b0, 1'b1, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 6'h2A, 16'd0, 26'd0, 1'b0);
        idle();

        // Randomized traffic
        go();
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                  16'($urandom), 26'($urandom), $urandom_range(0, 149) == 0);
        idle();

        // SW accepted, rst the next cycle: nothing follows, outputs at reset values
        go();
        drive(1'b0, 1'b1, 1'b0, 3'd5, 5'd4, 5'd6, 5'd0, 6'd0, 16'h00F0, 26'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'd5, 5'd4, 5'd6, 5'd0, 6'd0, 16'h00F4, 26'd0, 1'b1);
        @(negedge clk);
        chk("rst2_im_addr", {26'd0, bus.im_addr}, 32'd0);
        chk("rst2_im_wd", bus.im_wd, 32'd0);
        idle();
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
